// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer: queues I2C transaction commands in a small FIFO and
// issues them one at a time to an i2c_controller over its en/busy
// handshake, returning one response (read data or start-timeout error)
// per command.
module i2c_cmd_sequencer #(
  parameter int DEPTH         = 4,
  parameter int START_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  // command stream
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_mode,
  input  logic        cmd_rw,
  input  logic [6:0]  cmd_addr,
  input  logic [7:0]  cmd_reg,
  input  logic [15:0] cmd_data,
  // response stream
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  // controller interface
  output logic        ctl_en,
  output logic [1:0]  ctl_mode,
  output logic [6:0]  ctl_addr,
  output logic [7:0]  ctl_reg,
  output logic        ctl_rw,
  output logic [15:0] ctl_din,
  input  logic [15:0] ctl_dout,
  input  logic        ctl_busy,
  // status
  output logic        idle
);

  localparam int AW     = $clog2(DEPTH);
  localparam int TW_MIN = $clog2(START_TIMEOUT) + 1;
  localparam int TW     = (TW_MIN > 11) ? TW_MIN : 11;

  // One queued transaction; field order matches the 34-bit FIFO entry.
  typedef struct packed {
    logic [1:0]  mode;
    logic        rw;
    logic [6:0]  addr;
    logic [7:0]  regn;
    logic [15:0] data;
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_RUN
  } state_t;

  // ---------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------
  cmd_t        mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        empty, full, push, pop;
  cmd_t        cmd_in, head;

  assign cmd_in = '{mode: cmd_mode, rw: cmd_rw, addr: cmd_addr,
                    regn: cmd_reg, data: cmd_data};

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign head      = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance on push / pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
  end

  // FIFO storage write.
  // NOTE: storage is deliberately left without reset; the pointers alone
  // define which entries are valid, so clearing the array buys nothing.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= cmd_in;
  end

  // ---------------------------------------------------------------------
  // Issue FSM, controller fields, response and start timer
  // ---------------------------------------------------------------------
  state_t         state_q, state_d;
  logic           ctl_en_q, ctl_en_d;
  cmd_t           ctl_cmd_q, ctl_cmd_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [15:0]    rsp_data_q, rsp_data_d;
  logic           rsp_err_q, rsp_err_d;
  logic [TW-1:0]  timer_q, timer_d;

  // Next-state logic: issue from IDLE, wait for busy in START, wait for
  // completion in RUN; response cleared when the consumer takes it.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d     = state_q;
    ctl_en_d    = ctl_en_q;
    ctl_cmd_d   = ctl_cmd_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    timer_d     = timer_q;
    pop         = 1'b0;

    if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
      rsp_data_d  = '0;
      rsp_err_d   = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        // Registered rsp_valid gates issue, so a command goes out no
        // earlier than the cycle after its predecessor's response is taken.
        if (!empty && !rsp_valid_q) begin
          pop       = 1'b1;
          ctl_cmd_d = head;
          ctl_en_d  = 1'b1;
          timer_d   = '0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (ctl_busy) begin
          ctl_en_d = 1'b0;
          state_d  = S_RUN;
        end else if (timer_q == TW'(START_TIMEOUT - 1)) begin
          ctl_en_d    = 1'b0;
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
          rsp_valid_d = 1'b1;
          state_d     = S_IDLE;
        end else if (timer_q != '1) begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_RUN: begin
        if (!ctl_busy) begin
          rsp_data_d  = ctl_cmd_q.rw ? ctl_dout : 16'h0000;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and pointer registers; reset drops queued and in-flight work.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      state_q     <= S_IDLE;
      ctl_en_q    <= 1'b0;
      ctl_cmd_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      timer_q     <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      state_q     <= state_d;
      ctl_en_q    <= ctl_en_d;
      ctl_cmd_q   <= ctl_cmd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      timer_q     <= timer_d;
    end
  end

  assign ctl_en    = ctl_en_q;
  assign ctl_mode  = ctl_cmd_q.mode;
  assign ctl_rw    = ctl_cmd_q.rw;
  assign ctl_addr  = ctl_cmd_q.addr;
  assign ctl_reg   = ctl_cmd_q.regn;
  assign ctl_din   = ctl_cmd_q.data;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign idle      = empty && (state_q == S_IDLE) && !rsp_valid_q;

endmodule
